// File: rtl/uart_pkt_deframer_if.sv
// rtl/uart_pkt_deframer_if.sv - UART core receive-side read bus between core and deframer
interface uart_pkt_deframer_if;
   logic       RXRDY;
   logic [7:0] UART_DATA;
   logic       PARITY_ERR;
   logic       FRAMING_ERR;
   logic       OVERFLOW;
   logic       UART_CSN;
   logic       UART_OEN;

   modport master (
      output UART_CSN, UART_OEN,
      input  RXRDY, UART_DATA, PARITY_ERR, FRAMING_ERR, OVERFLOW
   );

   modport slave (
      input  UART_CSN, UART_OEN,
      output RXRDY, UART_DATA, PARITY_ERR, FRAMING_ERR, OVERFLOW
   );
endinterface

// File: rtl/uart_pkt_deframer.sv
// rtl/uart_pkt_deframer.sv - drains UART bytes, hunts SOF/LEN/payload/CHK frames, buffers valid packets
module uart_pkt_deframer #(
   parameter logic [7:0] SOF_BYTE    = 8'h7E,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                CLK,
   input  logic                RESET_N,
   uart_pkt_deframer_if.master uart,
   output logic                PKT_VALID,
   output logic [7:0]          PKT_LEN,
   input  logic                PKT_ACK,
   input  logic [7:0]          RD_ADDR,
   output logic [7:0]          RD_DATA,
   output logic                ERR_PULSE,
   output logic [7:0]          ERR_CNT
);
   localparam int          AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  MAX8  = 8'(MAX_LEN);
   localparam logic [15:0] TMO16 = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {R_IDLE, R_RD, R_WAIT} rd_state_t;
   typedef enum logic [2:0] {F_HUNT, F_LEN, F_PAY, F_CHK, F_DONE} fr_state_t;

   rd_state_t   rstate;
   fr_state_t   fstate;
   logic [7:0]  sum;
   logic [7:0]  idx;
   logic [15:0] tcnt;
   logic [7:0]  mem [MAX_LEN];

   logic       byte_stb;
   logic       line_err;
   logic       mid;
   logic       timeout_hit;
   logic       byte_drop;
   logic       drop;
   logic [7:0] din;

   // The byte is consumed on the edge that ends the strobe cycle, straight off the core's bus.
   always_comb begin
      din         = uart.UART_DATA;
      byte_stb    = (rstate == R_RD);
      line_err    = uart.PARITY_ERR | uart.FRAMING_ERR;
      mid         = (fstate == F_LEN) || (fstate == F_PAY) || (fstate == F_CHK);
      timeout_hit = mid && !byte_stb && (tcnt == TMO16 - 16'd1);
      byte_drop   = 1'b0;
      if (byte_stb) begin
         case (fstate)
            F_LEN:   byte_drop = line_err || (din == 8'd0) || (din > MAX8);
            F_PAY:   byte_drop = line_err;
            F_CHK:   byte_drop = line_err || ((sum + din) != 8'd0);
            default: byte_drop = 1'b0;
         endcase
      end
      drop = mid && (uart.OVERFLOW || timeout_hit || byte_drop);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rstate        <= R_IDLE;
         fstate        <= F_HUNT;
         uart.UART_CSN <= 1'b1;
         uart.UART_OEN <= 1'b1;
         PKT_VALID     <= 1'b0;
         PKT_LEN       <= 8'd0;
         RD_DATA       <= 8'd0;
         ERR_PULSE     <= 1'b0;
         ERR_CNT       <= 8'd0;
         sum           <= 8'd0;
         idx           <= 8'd0;
         tcnt          <= 16'd0;
      end else begin
         ERR_PULSE <= drop;
         if (drop && (ERR_CNT != 8'hFF))
            ERR_CNT <= ERR_CNT + 8'd1;

         case (rstate)
            R_IDLE: begin
               if (uart.RXRDY && (fstate != F_DONE)) begin
                  uart.UART_CSN <= 1'b0;
                  uart.UART_OEN <= 1'b0;
                  rstate        <= R_RD;
               end
            end
            R_RD: begin
               uart.UART_CSN <= 1'b1;
               uart.UART_OEN <= 1'b1;
               rstate        <= R_WAIT;
            end
            R_WAIT:  if (!uart.RXRDY) rstate <= R_IDLE;
            default: rstate <= R_IDLE;
         endcase

         if (!mid || byte_stb) tcnt <= 16'd0;
         else                  tcnt <= tcnt + 16'd1;

         if (drop) begin
            fstate <= F_HUNT;
         end else begin
            case (fstate)
               F_HUNT: if (byte_stb && !line_err && (din == SOF_BYTE)) fstate <= F_LEN;
               F_LEN: begin
                  if (byte_stb) begin
                     PKT_LEN <= din;
                     sum     <= din;
                     idx     <= 8'd0;
                     fstate  <= F_PAY;
                  end
               end
               F_PAY: begin
                  if (byte_stb) begin
                     sum <= sum + din;
                     idx <= idx + 8'd1;
                     if ((idx + 8'd1) == PKT_LEN) fstate <= F_CHK;
                  end
               end
               F_CHK: begin
                  if (byte_stb) begin
                     fstate    <= F_DONE;
                     PKT_VALID <= 1'b1;
                  end
               end
               F_DONE: begin
                  if (PKT_ACK) begin
                     fstate    <= F_HUNT;
                     PKT_VALID <= 1'b0;
                  end
               end
               default: fstate <= F_HUNT;
            endcase
         end

         if (RD_ADDR < MAX8)
            RD_DATA <= mem[RD_ADDR[AW-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (byte_stb && (fstate == F_PAY) && !drop)
         mem[idx[AW-1:0]] <= din;
   end
endmodule

// File: tb/tb_uart_pkt_deframer.sv
// tb/tb_uart_pkt_deframer.sv - directed plus randomized self-checking bench for uart_pkt_deframer
module tb_uart_pkt_deframer;
   localparam int         MAX_LEN = 16;
   localparam int         TMO     = 100;
   localparam logic [7:0] SOF     = 8'h7E;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       PKT_VALID;
   logic [7:0] PKT_LEN;
   logic       PKT_ACK;
   logic [7:0] RD_ADDR;
   logic [7:0] RD_DATA;
   logic       ERR_PULSE;
   logic [7:0] ERR_CNT;

   uart_pkt_deframer_if u_if ();

   uart_pkt_deframer #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .uart(u_if.master),
      .PKT_VALID(PKT_VALID), .PKT_LEN(PKT_LEN), .PKT_ACK(PKT_ACK),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .ERR_PULSE(ERR_PULSE), .ERR_CNT(ERR_CNT)
   );

   always #5 CLK = ~CLK;

   int         tests = 0;
   int         fails = 0;
   int         exp_cnt = 0;
   logic [7:0] txq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART core model: raise RXRDY, wait for the strobe, drop RXRDY after the consuming edge.
   task automatic send_byte(input logic [7:0] b, input bit perr, input bit ferr,
                            output bit got, output bit pulse);
      u_if.UART_DATA   = b;
      u_if.PARITY_ERR  = perr;
      u_if.FRAMING_ERR = ferr;
      u_if.RXRDY       = 1'b1;
      got   = 1'b0;
      pulse = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!u_if.UART_CSN && !u_if.UART_OEN) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         @(posedge CLK);
         #1 pulse = ERR_PULSE;
      end
      u_if.RXRDY       = 1'b0;
      u_if.PARITY_ERR  = 1'b0;
      u_if.FRAMING_ERR = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_q(input int perr_at, output bit pulse);
      bit got;
      pulse = 1'b0;
      foreach (txq[i]) begin
         send_byte(txq[i], (i == perr_at), 1'b0, got, pulse);
         check("strobe", got, 1);
      end
   endtask

   function automatic logic [7:0] chk_of();
      int s = 0;
      for (int i = 1; i < txq.size(); i++) s += txq[i];
      return 8'((256 - (s % 256)) % 256);
   endfunction

   // Reference: a frame is accepted only if it is clean, LEN is in 1..MAX_LEN and LEN+payload+CHK sums to 0 mod 256.
   function automatic bit model_accept(input int perr_at);
      int len, s;
      if (perr_at >= 0) return 1'b0;
      len = txq[1];
      if (len == 0 || len > MAX_LEN) return 1'b0;
      if (txq.size() != len + 3) return 1'b0;
      s = 0;
      for (int i = 1; i < len + 3; i++) s += txq[i];
      return (s % 256) == 0;
   endfunction

   function automatic void count_drop();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
   endfunction

   task automatic read_check(input string tag);
      int len = txq[1];
      for (int i = 0; i < len; i++) begin
         @(negedge CLK) RD_ADDR = 8'(i);
         @(negedge CLK) check(tag, RD_DATA, txq[i + 2]);
      end
   endtask

   task automatic ack(input string tag);
      @(negedge CLK) PKT_ACK = 1'b1;
      @(posedge CLK);
      #1 check(tag, PKT_VALID, 0);
      PKT_ACK = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int perr_at);
      bit pulse, ok;
      ok = model_accept(perr_at);
      send_q(perr_at, pulse);
      if (ok) begin
         check({tag, "_valid"}, PKT_VALID, 1);
         check({tag, "_len"}, PKT_LEN, txq[1]);
         check({tag, "_pulse"}, pulse, 0);
         read_check({tag, "_data"});
         check({tag, "_cnt"}, ERR_CNT, exp_cnt);
         ack({tag, "_ack"});
      end else begin
         count_drop();
         check({tag, "_valid"}, PKT_VALID, 0);
         check({tag, "_pulse"}, pulse, 1);
         check({tag, "_cnt"}, ERR_CNT, exp_cnt);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_csn"}, u_if.UART_CSN, 1);
      check({tag, "_oen"}, u_if.UART_OEN, 1);
      check({tag, "_valid"}, PKT_VALID, 0);
      check({tag, "_len"}, PKT_LEN, 0);
      check({tag, "_rdata"}, RD_DATA, 0);
      check({tag, "_pulse"}, ERR_PULSE, 0);
      check({tag, "_cnt"}, ERR_CNT, 0);
   endtask

   initial begin
      bit         got, pulse;
      int         n, strobes, len, pe;
      RESET_N = 1'b0; PKT_ACK = 1'b0; RD_ADDR = 8'd0;
      u_if.RXRDY = 1'b0; u_if.UART_DATA = 8'd0; u_if.PARITY_ERR = 1'b0;
      u_if.FRAMING_ERR = 1'b0; u_if.OVERFLOW = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      RESET_N = 1'b1;
      @(negedge CLK);

      txq = '{SOF, 8'h03, 8'h11, 8'h22, 8'h33}; txq.push_back(chk_of());
      run_frame("good3", -1);

      txq = '{SOF, 8'h02, 8'hAA, 8'h55, 8'h00};
      run_frame("badchk", -1);
      txq = '{SOF, 8'h01, 8'h7E}; txq.push_back(chk_of());
      run_frame("sofdata", -1);

      txq = '{SOF, 8'h00};
      run_frame("len0", -1);
      txq = '{SOF, 8'h11};
      run_frame("len17", -1);
      txq = '{SOF, 8'h10};
      for (int i = 0; i < 16; i++) txq.push_back(8'($urandom));
      txq.push_back(chk_of());
      run_frame("len16", -1);

      txq = '{SOF, 8'h02, 8'hAA};
      send_q(-1, pulse);
      n = 1;
      for (int j = 0; j < 300; j++) begin
         @(posedge CLK);
         #1 n++;
         if (ERR_PULSE) break;
      end
      count_drop();
      check("tmo_edge", n, TMO);
      check("tmo_cnt", ERR_CNT, exp_cnt);
      @(posedge CLK);
      #1 check("tmo_pulse_once", ERR_PULSE, 0);
      txq = '{SOF, 8'h02, 8'h5A, 8'hC3}; txq.push_back(chk_of());
      run_frame("after_tmo", -1);

      txq = '{SOF, 8'h03, 8'h01, 8'h02};
      run_frame("parity_pay", 3);
      send_byte(SOF, 1'b0, 1'b1, got, pulse);
      check("ferr_hunt_pulse", pulse, 0);
      check("ferr_hunt_cnt", ERR_CNT, exp_cnt);
      txq = '{SOF, 8'h01, 8'h05}; txq.push_back(chk_of());
      run_frame("after_ferr", -1);

      txq = '{SOF, 8'h02, 8'h01};
      send_q(-1, pulse);
      @(negedge CLK) u_if.OVERFLOW = 1'b1;
      @(posedge CLK);
      #1 check("ovf_pulse", ERR_PULSE, 1);
      u_if.OVERFLOW = 1'b0;
      count_drop();
      check("ovf_cnt", ERR_CNT, exp_cnt);

      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, MAX_LEN + 2);
         txq = '{SOF, 8'(len)};
         if (len >= 1 && len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) txq.push_back(8'($urandom));
            txq.push_back(($urandom_range(0, 3) == 0) ? 8'(chk_of() + 8'($urandom_range(1, 255)))
                                                     : chk_of());
         end
         pe = -1;
         if ($urandom_range(0, 7) == 0) begin
            pe = $urandom_range(1, txq.size() - 1);
            while (txq.size() > pe + 1) void'(txq.pop_back());
         end
         run_frame("rand", pe);
      end

      txq = '{SOF, 8'h02, 8'h10, 8'h20}; txq.push_back(chk_of());
      run_frame("bp_pkt_pre", -1);
      txq = '{SOF, 8'h01, 8'h44}; txq.push_back(chk_of());
      send_q(-1, pulse);
      check("bp_valid", PKT_VALID, 1);
      u_if.UART_DATA = 8'h00;
      u_if.RXRDY = 1'b1;
      strobes = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (!u_if.UART_CSN || !u_if.UART_OEN) strobes++;
      end
      check("bp_no_strobe", strobes, 0);
      check("bp_len_stable", PKT_LEN, 1);
      ack("bp_ack");
      send_byte(8'h00, 1'b0, 1'b0, got, pulse);
      check("bp_resume", got, 1);

      for (int i = 0; i < 300; i++) begin
         txq = '{SOF, 8'h00};
         send_q(-1, pulse);
         count_drop();
      end
      check("sat_cnt", ERR_CNT, 255);
      check("sat_model", ERR_CNT, exp_cnt);

      txq = '{SOF, 8'h04, 8'h01};
      send_q(-1, pulse);
      @(negedge CLK) RESET_N = 1'b0;
      #1 check_reset_vals("midreset");
      @(negedge CLK) RESET_N = 1'b1;
      exp_cnt = 0;
      txq = '{SOF, 8'h01, 8'h99}; txq.push_back(chk_of());
      run_frame("post_reset", -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
